// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, FSM states and flag helper shared by the ALU files.
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MULU = 4'b0010;
  localparam logic [3:0] OP_DIVU = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;
  typedef enum logic {S_IDLE, S_ITER} state_t;
  // Signed overflow from operand and result sign bits; sub compares against -b.
  function automatic logic ovf(input logic sa, input logic sb, input logic sr, input logic sub);
    return sub ? (sa != sb) && (sr != sa) : (sa == sb) && (sr != sa);
  endfunction
endpackage

// File: rtl/alu_muldiv_core.sv
// alu_muldiv_core: iterative shift-add multiplier / restoring divider, one bit per step.
module alu_muldiv_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             finish,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum, diff;
  // hi/lo are the next-step values, so the top can capture the result on the final step.
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    diff = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};
    hi   = div_q ? (diff[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : diff[WIDTH-1:0]) : sum[WIDTH:1];
    lo   = div_q ? {lo_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
  end
  assign finish      = step && (cnt_q == CW'(WIDTH - 1));
  assign div_by_zero = div_q && (b_q == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      div_q <= div;
      cnt_q <= '0;
    end else if (step) begin
      hi_q  <= hi;
      lo_q  <= lo;
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit ALU with start/busy/done handshake; MULU/DIVU run WIDTH cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             overflow,
  output logic             less_than_flag,
  output logic             is_equal,
  output logic             zero_flag,
  output logic             div_by_zero
);
  state_t           state_q;
  logic             busy_q, done_q, ovf_q, lt_q, eq_q, zf_q, dz_q;
  logic [WIDTH-1:0] out_q, hi_q, lo_q;
  logic             md_op, md_load, md_fin, md_dz, lt, eq, sc_ovf;
  logic [WIDTH-1:0] md_hi, md_lo, sum, dif, sc_res;
  assign md_op   = (ALU_OP == OP_MULU) || (ALU_OP == OP_DIVU);
  assign md_load = (state_q == S_IDLE) && start && md_op;
  alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (md_load),
    .div        (ALU_OP == OP_DIVU),
    .step       (state_q == S_ITER),
    .a          (A),
    .b          (B),
    .finish     (md_fin),
    .hi         (md_hi),
    .lo         (md_lo),
    .div_by_zero(md_dz)
  );
  // Shifts rely on SV semantics: amounts >= WIDTH yield 0, or sign fill for >>>.
  always_comb begin
    sum = A + B;
    dif = A - B;
    lt  = $signed(A) < $signed(B);
    eq  = A == B;
    case (ALU_OP)
      OP_ADD:  sc_res = sum;
      OP_SUB:  sc_res = dif;
      OP_SLL:  sc_res = A << B;
      OP_SRA:  sc_res = $signed(A) >>> B;
      OP_SRL:  sc_res = A >> B;
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NAND: sc_res = ~(A & B);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, lt};
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, eq};
      default: sc_res = '0;
    endcase
    sc_ovf = (ALU_OP == OP_ADD) ? ovf(A[WIDTH-1], B[WIDTH-1], sum[WIDTH-1], 1'b0) :
             (ALU_OP == OP_SUB) ? ovf(A[WIDTH-1], B[WIDTH-1], dif[WIDTH-1], 1'b1) : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      zf_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          if (md_op) begin
            state_q <= S_ITER;
            busy_q  <= 1'b1;
          end else begin
            done_q <= 1'b1;
            out_q  <= sc_res;
            ovf_q  <= sc_ovf;
            lt_q   <= (ALU_OP == OP_SLT) && lt;
            eq_q   <= (ALU_OP == OP_EQ) && eq;
            zf_q   <= sc_res == '0;
            dz_q   <= 1'b0;
          end
        end
        S_ITER: if (md_fin) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          hi_q    <= md_hi;
          lo_q    <= md_lo;
          out_q   <= md_lo;
          ovf_q   <= 1'b0;
          lt_q    <= 1'b0;
          eq_q    <= 1'b0;
          zf_q    <= md_lo == '0;
          dz_q    <= md_dz;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy           = busy_q;
  assign done           = done_q;
  assign ALU_Out        = out_q;
  assign HI             = hi_q;
  assign LO             = lo_q;
  assign overflow       = ovf_q;
  assign less_than_flag = lt_q;
  assign is_equal       = eq_q;
  assign zero_flag      = zf_q;
  assign div_by_zero    = dz_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus hand sequences for multi-cycle corners of alu_seq.
module tb_alu_seq;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] op = 4'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       busy, done, ovf, ltf, eqf, zf, dz;
  logic [7:0] out, hi, lo;
  int         n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ALU_OP(op), .A(a), .B(b),
    .busy(busy), .done(done), .ALU_Out(out), .HI(hi), .LO(lo),
    .overflow(ovf), .less_than_flag(ltf), .is_equal(eqf), .zero_flag(zf), .div_by_zero(dz)
  );
  // flags packed as {overflow, less_than, is_equal, zero, div_by_zero}
  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, out;
    logic [4:0] flg;
    logic       md;
    logic [7:0] hi, lo;
  } vec_t;
  vec_t vecs[$];
  logic [7:0] exp_hi = 8'h00, exp_lo = 8'h00;
  int lat, bc;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bc = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask
  initial begin
    logic seen;
    vecs.push_back('{4'b0000, 8'h01, 8'hFF, 8'h00, 5'b00010, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b0000, 8'h7F, 8'h01, 8'h80, 5'b10000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b0001, 8'h01, 8'hFF, 8'h02, 5'b00000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b0001, 8'h80, 8'h01, 8'h7F, 5'b10000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b0010, 8'hFF, 8'hFF, 8'h01, 5'b00000, 1'b1, 8'hFE, 8'h01});
    vecs.push_back('{4'b0010, 8'h0D, 8'h0B, 8'h8F, 5'b00000, 1'b1, 8'h00, 8'h8F});
    vecs.push_back('{4'b0011, 8'hC8, 8'h07, 8'h1C, 5'b00000, 1'b1, 8'h04, 8'h1C});
    vecs.push_back('{4'b0011, 8'h05, 8'h09, 8'h00, 5'b00010, 1'b1, 8'h05, 8'h00});
    vecs.push_back('{4'b0011, 8'hC8, 8'h00, 8'hFF, 5'b00001, 1'b1, 8'hC8, 8'hFF});
    vecs.push_back('{4'b0101, 8'h80, 8'h07, 8'hFF, 5'b00000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b0100, 8'h01, 8'h07, 8'h80, 5'b00000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b0100, 8'h01, 8'h08, 8'h00, 5'b00010, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b0101, 8'h80, 8'h0C, 8'hFF, 5'b00000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b0101, 8'h40, 8'h02, 8'h10, 5'b00000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b0110, 8'h80, 8'h07, 8'h01, 5'b00000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b0110, 8'hF0, 8'h08, 8'h00, 5'b00010, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b1000, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b1001, 8'hF0, 8'h0F, 8'hFF, 5'b00000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b1010, 8'hFF, 8'h0F, 8'hF0, 5'b00000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b1100, 8'h00, 8'h00, 8'hFF, 5'b00000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b1110, 8'hFF, 8'h01, 8'h01, 5'b01000, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b1110, 8'h01, 8'hFF, 8'h00, 5'b00010, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b1111, 8'hFF, 8'hFF, 8'h01, 5'b00100, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b1111, 8'h01, 8'h02, 8'h00, 5'b00010, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{4'b0111, 8'h12, 8'h34, 8'h00, 5'b00010, 1'b0, 8'h00, 8'h00});
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, out, hi, lo, ovf, ltf, eqf, zf, dz}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b);
      if (vecs[i].md) begin
        exp_hi = vecs[i].hi;
        exp_lo = vecs[i].lo;
      end
      chk($sformatf("v%0d_out", i), out, vecs[i].out);
      chk($sformatf("v%0d_flags", i), {ovf, ltf, eqf, zf, dz}, vecs[i].flg);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].md ? 8 : 0);
      chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].md ? 8 : 0);
      chk($sformatf("v%0d_hilo", i), {hi, lo}, {exp_hi, exp_lo});
      chk($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
    end
    // MULU with an ignored ADD start mid-op
    @(negedge clk);
    start = 1'b1; op = 4'b0010; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mulu_busy_after_start", {busy, done}, 2'b10);
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    start = 1'b1; op = 4'b0000; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h33; b = 8'h44;
    chk("mulu_hilo_held_midop", {hi, lo}, {exp_hi, exp_lo});
    lat = 3;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mulu_ignore_latency", lat, 8);
    chk("mulu_ignore_result", {out, hi, lo, busy}, {8'h01, 8'hFE, 8'h01, 1'b0});
    exp_hi = 8'hFE; exp_lo = 8'h01;
    @(posedge clk); #1;
    chk("mulu_done_pulse_one_cycle", {done, busy, out}, {1'b0, 1'b0, 8'h01});
    // back-to-back single-cycle ops with start held high
    @(negedge clk);
    start = 1'b1; op = 4'b0000; a = 8'h01; b = 8'h02;
    @(posedge clk); #1;
    chk("b2b_first", {done, out}, {1'b1, 8'h03});
    op = 4'b1010; a = 8'h0F; b = 8'h0F;
    @(posedge clk); #1;
    chk("b2b_second", {done, out, zf}, {1'b1, 8'h00, 1'b1});
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done_falls", {done, out}, {1'b0, 8'h00});
    // reset 3 cycles into a MULU aborts it
    @(negedge clk);
    start = 1'b1; op = 4'b0010; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_reset_outputs", {busy, done, out, hi, lo, ovf, ltf, eqf, zf, dz}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | done | busy;
    end
    chk("abort_no_done", seen, 1'b0);
    do_op(4'b0000, 8'h7F, 8'h01);
    chk("post_abort_add", {out, ovf, zf}, {8'h80, 1'b1, 1'b0});
    chk("post_abort_latency", lat, 0);
    chk("post_abort_hilo", {hi, lo}, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the 8-bit datapath ALU. It keeps the existing 4-bit opcode map and flag outputs, generalises the datapath to WIDTH bits, and adds a start/busy/done handshake. Unsigned multiply is an iterative shift-add and unsigned divide is an iterative restoring divide; each takes WIDTH cycles, while all other ops complete in one cycle. The block sits between the register file and writeback, and the control FSM stalls on `busy`.

## Interface
- `WIDTH`, 8: operand/result width; ≥4, power of two.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only when `busy`=0.
- `ALU_OP` in 4: opcode, latched with `start`.
- `A`, `B` in WIDTH: operands, latched with `start`.
- `busy` out 1: multi-cycle op in progress.
- `done` out 1: one-cycle pulse, results valid.
- `ALU_Out` out WIDTH: primary result (registered).
- `HI`, `LO` out WIDTH: mul/div result registers.
- `overflow`, `less_than_flag`, `is_equal`, `zero_flag`, `div_by_zero` out 1: registered flags.

## Operation
- Opcodes:
  - 0000 ADD; 0001 SUB; 0010 MULU; 0011 DIVU.
  - 0100 SLL; 0101 SRA; 0110 SRL.
  - 1000 AND; 1001 OR; 1010 XOR; 1100 NAND.
  - 1110 SLT (signed); 1111 EQ.
  - Unused codes: `ALU_Out`=0, complete as single-cycle.
- Add/sub: wrap modulo 2^WIDTH. `overflow` is signed two's-complement overflow; it is 0 for every other op.
- MULU: {HI,LO} = A*B, full 2·WIDTH product. `ALU_Out`=LO.
- DIVU: LO = quotient, HI = remainder, `ALU_Out` = quotient.
  - B=0: quotient all-ones, remainder = A, `div_by_zero`=1, full latency still used.
  - `div_by_zero` is 0 after every other op.
- Shifts: A is the value; B is the unsigned shift amount.
  - B ≥ WIDTH: SLL/SRL give 0; SRA gives WIDTH copies of A[MSB].
- SLT: `ALU_Out` = {0…0, A<B signed}; `less_than_flag` is the same bit.
- EQ: `ALU_Out` = {0…0, A==B}; `is_equal` is the same bit.
- `less_than_flag` and `is_equal` are 0 after ops other than SLT/EQ.
- `zero_flag` = (`ALU_Out`==0) for every completed op.
- HI/LO change only on MULU/DIVU completion. All outputs hold between completions.
- FSM states:
  - IDLE: `start` with single-cycle op → IDLE (results written); with MULU/DIVU → ITER, count=0.
  - ITER: one shift-add or shift-subtract step per cycle, count++; when count=WIDTH−1 → IDLE (results written).
- `start` while `busy`=1 is ignored; no queueing.

## Timing
- Reset: every output 0 (HI, LO, `ALU_Out`, all flags, `busy`, `done`); state IDLE.
- `rst` mid-ITER aborts the op; no `done` is produced and HI/LO are cleared.
- Single-cycle op: `start` sampled at edge k → results and `done`=1 visible after edge k; `done` falls after edge k+1.
- MULU/DIVU: `start` at edge k → `busy`=1 after edges k…k+WIDTH−1. Results, `done`=1 and `busy`=0 appear after edge k+WIDTH, i.e. latency WIDTH cycles.
- Back-to-back: `start` is accepted in the same cycle `done`=1, giving throughput of 1 op/cycle for single-cycle ops.
- Operand or opcode changes while `busy` have no effect.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams (OP_ADD…OP_EQ);
  - FSM state enum {S_IDLE, S_ITER};
  - helper function for signed overflow.
- Sub-module `alu_muldiv_core`:
  - holds the iterative multiplier/divider, its accumulator and its counter;
  - interface is load/op/step/finish;
  - is parametrised by WIDTH.
- The top level holds the FSM, the single-cycle combinational ops and the output registers.

## Test plan
All scenarios use WIDTH=8.
- ADD: A=01, B=FF → `ALU_Out`=00, `zero_flag`=1, `overflow`=0, `done` 1 cycle after `start`.
- ADD: A=7F, B=01 → 80, `overflow`=1.
- SUB: A=01, B=FF → 02.
- MULU: A=FF, B=FF → HI=FE, LO=01, `ALU_Out`=01.
  - `busy` high exactly 8 cycles; `done` after 8.
  - A second `start` (ADD) mid-op is ignored; HI/LO unchanged until completion.
- DIVU: A=C8, B=07 → LO=1C, HI=04.
- DIVU: A=C8, B=00 → LO=FF, HI=C8, `div_by_zero`=1, latency 8.
- Shifts:
  - SRA: A=80, B=07 → FF.
  - SLL: A=01, B=07 → 80.
  - SLL: A=01, B=08 → 00.
  - SRA: A=80, B=0C → FF.
- Compare:
  - SLT: A=FF, B=01 → `ALU_Out`=01, `less_than_flag`=1.
  - EQ: A=FF, B=FF → `is_equal`=1.
  - NAND: A=00, B=00 → FF.
- Reset 3 cycles into MULU → all outputs 0, no `done`. A following ADD completes normally in 1 cycle.
